// File: rtl/lcd2vga_pkg.sv
// -----------------------------------------------------------------------------
// lcd2vga_pkg
// Shared definitions for the LCD-to-VGA sync lock logic.
//   - lock_state_t : sync lock FSM encoding (SEARCH=0, MEASURE=1, LOCKED=2, LOST=3)
//   - VGA 640x480 timing constants (totals, active area, vertical blanking)
//   - abs_diff     : unsigned absolute difference used for period matching
// -----------------------------------------------------------------------------
package lcd2vga_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } lock_state_t;

    // VGA 640x480 frame geometry, in pixel clocks / lines
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_BLANK  = 45;

    localparam int CNT_W = 32;

    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/lcd_sync_edge_det.sv
// -----------------------------------------------------------------------------
// lcd_sync_edge_det
// Rising-edge detector for the LCD frame sync (already in the iw_clk domain).
// Ports:
//   iw_clk   in  sole clock
//   iw_rst_n in  synchronous active-low reset
//   iw_sync  in  LCD frame sync level
//   ow_edge  out high in the cycle where iw_sync=1 and the previous sample=0
// The previous-sample register resets to 1 so a sync that is already high
// when reset is released is not mistaken for a fresh edge.
// -----------------------------------------------------------------------------
module lcd_sync_edge_det (
    input  logic iw_clk,
    input  logic iw_rst_n,
    input  logic iw_sync,
    output logic ow_edge
);

    logic sync_prev_reg;

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            sync_prev_reg <= 1'b1;
        end else begin
            sync_prev_reg <= iw_sync;
        end
    end

    assign ow_edge = iw_sync & ~sync_prev_reg;

endmodule

// File: rtl/lcd_sync_lock_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_sync_lock_ctrl
// Measures the LCD frame sync period, locks after P_LOCK_FRAMES consecutive
// matching periods, and then emits one restart pulse per frame, P_SYNC_OFFSET
// clocks after the sync rising edge, to realign the VGA hpos/vpos generator.
//
// Ports:
//   iw_clk       in   sole clock
//   iw_rst_n     in   synchronous active-low reset
//   iw_sync      in   LCD frame sync (synchronous to iw_clk)
//   ow_restart   out  one-cycle restart pulse (LOCKED only)
//   ow_locked    out  high in LOCKED
//   ow_video_en  out  RGB pass-through enable
//   ow_state     out  FSM state (SEARCH=0, MEASURE=1, LOCKED=2, LOST=3)
//   ow_frame_len out  last accepted sync period, in clocks
//   ow_lost_cnt  out  lock-loss events, saturating at 255
//
// Build option: define SYNC_WATCHDOG_EN to drop lock when no sync edge has
// arrived by ow_frame_len+P_TOL+1 clocks after the last one. Without it a
// missing sync leaves the block in LOCKED, silently waiting for the next edge.
// -----------------------------------------------------------------------------
module lcd_sync_lock_ctrl
    import lcd2vga_pkg::*;
#(
    parameter int P_SYNC_OFFSET = 36203,   // 800*44+1003
    parameter int P_FRAME_MIN   = 400000,
    parameter int P_FRAME_MAX   = 440000,
    parameter int P_TOL         = 4,
    parameter int P_LOCK_FRAMES = 3
) (
    input  logic        iw_clk,
    input  logic        iw_rst_n,
    input  logic        iw_sync,
    output logic        ow_restart,
    output logic        ow_locked,
    output logic        ow_video_en,
    output logic [1:0]  ow_state,
    output logic [31:0] ow_frame_len,
    output logic [7:0]  ow_lost_cnt
);

    // The restart must land inside every accepted frame, and locking needs
    // at least one matching period.
    if (P_SYNC_OFFSET >= P_FRAME_MIN || P_LOCK_FRAMES < 1) begin : g_param_check
        $fatal(1, "lcd_sync_lock_ctrl: need P_SYNC_OFFSET < P_FRAME_MIN and P_LOCK_FRAMES >= 1");
    end

    localparam int MATCH_W = (P_LOCK_FRAMES < 2) ? 1 : $clog2(P_LOCK_FRAMES + 1);
    localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(P_LOCK_FRAMES);

    lock_state_t        state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CNT_W-1:0]   frame_len_reg, frame_len_next;
    logic [MATCH_W-1:0] match_reg, match_next;
    logic [7:0]         lost_cnt_reg, lost_cnt_next;
    logic               video_en_reg, video_en_next;

    logic sync_edge;
    logic period_valid;
    logic period_match;
    logic restart;
    logic wd_expired;

    lcd_sync_edge_det u_edge_det (
        .iw_clk   (iw_clk),
        .iw_rst_n (iw_rst_n),
        .iw_sync  (iw_sync),
        .ow_edge  (sync_edge)
    );

    // At an edge cycle cnt_reg holds the period just completed.
    assign period_valid = (cnt_reg >= CNT_W'(P_FRAME_MIN)) && (cnt_reg <= CNT_W'(P_FRAME_MAX));
    assign period_match = period_valid && (abs_diff(cnt_reg, frame_len_reg) <= CNT_W'(P_TOL));

    // A sync edge on the offset cycle clears the counter instead, so no pulse.
    // The counter passes the offset only once per period, so this fires at
    // most once per frame.
    assign restart = (state_reg == ST_LOCKED) && (cnt_reg == CNT_W'(P_SYNC_OFFSET)) && !sync_edge;

`ifdef SYNC_WATCHDOG_EN
    // One extra bit so frame_len near the top of the range cannot wrap.
    assign wd_expired = ({1'b0, cnt_reg} >= ({1'b0, frame_len_reg} + (CNT_W+1)'(P_TOL) + (CNT_W+1)'(1)));
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        frame_len_next = frame_len_reg;
        match_next     = match_reg;
        lost_cnt_next  = lost_cnt_reg;

        if (sync_edge) begin
            cnt_next = '0;
        end else if (cnt_reg == {CNT_W{1'b1}}) begin
            cnt_next = cnt_reg;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            ST_SEARCH: begin
                // The first edge only starts a measurement; the time since
                // reset or loss is not a real frame period.
                if (sync_edge) begin
                    state_next = ST_MEASURE;
                    match_next = '0;
                end
            end
            ST_MEASURE: begin
                if (sync_edge) begin
                    if (period_valid) begin
                        frame_len_next = cnt_reg;
                    end
                    if (period_match) begin
                        match_next = match_reg + MATCH_W'(1);
                        if (match_reg + MATCH_W'(1) == LOCK_TARGET) begin
                            state_next = ST_LOCKED;
                        end
                    end else begin
                        match_next = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (sync_edge) begin
                    if (period_match) begin
                        frame_len_next = cnt_reg;
                    end else begin
                        state_next = ST_LOST;
                    end
                end else if (wd_expired) begin
                    state_next = ST_LOST;
                end
            end
            ST_LOST: begin
                state_next = ST_SEARCH;
                if (lost_cnt_reg != 8'hFF) begin
                    lost_cnt_next = lost_cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_SEARCH;
            end
        endcase

        // Video turns on after the first restart realigns the VGA timing and
        // drops in the same cycle the FSM leaves LOCKED.
        video_en_next = (state_next == ST_LOCKED) && (video_en_reg || restart);
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            state_reg     <= ST_SEARCH;
            cnt_reg       <= '0;
            frame_len_reg <= '0;
            match_reg     <= '0;
            lost_cnt_reg  <= '0;
            video_en_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            frame_len_reg <= frame_len_next;
            match_reg     <= match_next;
            lost_cnt_reg  <= lost_cnt_next;
            video_en_reg  <= video_en_next;
        end
    end

    assign ow_restart   = restart;
    assign ow_locked    = (state_reg == ST_LOCKED);
    assign ow_video_en  = video_en_reg;
    assign ow_state     = state_reg;
    assign ow_frame_len = frame_len_reg;
    assign ow_lost_cnt  = lost_cnt_reg;

endmodule

// File: tb/tb_lcd_sync_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_sync_lock_ctrl
// Scoreboard bench: each sync edge pushes the state transitions and restart
// pulse it should cause; a negedge monitor pops and compares them when the
// DUT changes state or pulses ow_restart. Direct checks cover register values.
// A measured period P means P+1 clocks between sync rising edges (the counter
// reads 0 one cycle after an edge).
// -----------------------------------------------------------------------------
module tb_lcd_sync_lock_ctrl;

    localparam int OFFS = 20;
    localparam int FMIN = 90;
    localparam int FMAX = 110;
    localparam int TOL  = 2;
    localparam int LOCKN = 3;

    localparam int S_NONE    = -1;
    localparam int S_SEARCH  = 0;
    localparam int S_MEASURE = 1;
    localparam int S_LOCKED  = 2;
    localparam int S_LOST    = 3;

    logic        iw_clk = 1'b0;
    logic        iw_rst_n = 1'b0;
    logic        iw_sync = 1'b0;
    logic        ow_restart;
    logic        ow_locked;
    logic        ow_video_en;
    logic [1:0]  ow_state;
    logic [31:0] ow_frame_len;
    logic [7:0]  ow_lost_cnt;

    lcd_sync_lock_ctrl #(
        .P_SYNC_OFFSET (OFFS),
        .P_FRAME_MIN   (FMIN),
        .P_FRAME_MAX   (FMAX),
        .P_TOL         (TOL),
        .P_LOCK_FRAMES (LOCKN)
    ) u_dut (
        .iw_clk       (iw_clk),
        .iw_rst_n     (iw_rst_n),
        .iw_sync      (iw_sync),
        .ow_restart   (ow_restart),
        .ow_locked    (ow_locked),
        .ow_video_en  (ow_video_en),
        .ow_state     (ow_state),
        .ow_frame_len (ow_frame_len),
        .ow_lost_cnt  (ow_lost_cnt)
    );

    always #5 iw_clk = ~iw_clk;

    int cyc = 0;
    always @(posedge iw_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] st;
    } st_exp_t;

    st_exp_t state_q[$];
    int      restart_q[$];
    int      n_checks = 0;
    int      n_errors = 0;
    int      last_e = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: compare every state change and restart pulse with the queues.
    logic [1:0] prev_state = 2'd0;
    st_exp_t    mon_e;
    int         mon_r;
    always @(negedge iw_clk) begin
        if (ow_state !== prev_state) begin
            if (state_q.size() == 0) begin
                check("state_unexpected", 64'(ow_state), 64'(prev_state));
            end else begin
                mon_e = state_q.pop_front();
                check("state_cyc", 64'(cyc), 64'(mon_e.cyc));
                check("state_val", 64'(ow_state), 64'(mon_e.st));
            end
            prev_state = ow_state;
        end
        if (ow_restart === 1'b1) begin
            if (restart_q.size() == 0) begin
                check("restart_spurious", 64'(1), 64'(0));
            end else begin
                mon_r = restart_q.pop_front();
                check("restart_cyc", 64'(cyc), 64'(mon_r));
            end
        end
    end

    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    // One-cycle sync pulse; queues the transitions at E+1 / E+2 and a
    // restart at E+OFFS+1 when requested.
    task automatic pulse(input int st1, input int st2, input bit exp_restart);
        last_e = cyc;
        if (st1 >= 0) state_q.push_back('{cyc: cyc + 1, st: 2'(st1)});
        if (st2 >= 0) state_q.push_back('{cyc: cyc + 2, st: 2'(st2)});
        if (exp_restart) restart_q.push_back(cyc + OFFS + 1);
        $display("edge at cycle %0d state=%0d frame_len=%0d", cyc, ow_state, ow_frame_len);
        iw_sync = 1'b1;
        tick();
        iw_sync = 1'b0;
    endtask

    // Next edge placed so the measured period equals p.
    task automatic edge_after(input int p, input int st1, input int st2, input bit exp_restart);
        while (cyc < last_e + p + 1) tick();
        pulse(st1, st2, exp_restart);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        // Reset with sync held high: releasing reset must not see an edge.
        iw_rst_n = 1'b0;
        iw_sync  = 1'b1;
        repeat (3) tick();
        check("rst_state", 64'(ow_state), 64'(S_SEARCH));
        check("rst_locked", 64'(ow_locked), 64'(0));
        check("rst_video", 64'(ow_video_en), 64'(0));
        check("rst_frame_len", 64'(ow_frame_len), 64'(0));
        check("rst_lost_cnt", 64'(ow_lost_cnt), 64'(0));
        check("rst_restart", 64'(ow_restart), 64'(0));
        iw_rst_n = 1'b1;
        repeat (5) tick();
        check("no_false_edge", 64'(ow_state), 64'(S_SEARCH));
        iw_sync = 1'b0;
        repeat (5) tick();

        // Steady period 100: SEARCH edge, then 100 mismatches frame_len=0,
        // then three matches lock.
        pulse(S_MEASURE, S_NONE, 1'b0);
        edge_after(100, S_NONE, S_NONE, 1'b0);
        edge_after(100, S_NONE, S_NONE, 1'b0);
        edge_after(100, S_NONE, S_NONE, 1'b0);
        edge_after(100, S_LOCKED, S_NONE, 1'b1);
        wait_until(last_e + 30);
        check("lock_locked", 64'(ow_locked), 64'(1));
        check("lock_video", 64'(ow_video_en), 64'(1));
        check("lock_frame_len", 64'(ow_frame_len), 64'(100));
        edge_after(100, S_NONE, S_NONE, 1'b1);
        edge_after(100, S_NONE, S_NONE, 1'b1);
        check("locked_frame_len", 64'(ow_frame_len), 64'(100));

        // Period 95 while locked: outside tolerance -> LOST then SEARCH.
        edge_after(95, S_LOST, S_SEARCH, 1'b0);
        repeat (3) tick();
        check("lost1_cnt", 64'(ow_lost_cnt), 64'(1));
        check("lost1_video", 64'(ow_video_en), 64'(0));
        check("lost1_locked", 64'(ow_locked), 64'(0));
        check("lost1_frame_len", 64'(ow_frame_len), 64'(100));

        // Relock against the retained frame_len=100 (three MEASURE matches),
        // then an edge exactly on the restart cycle: edge wins, no restart.
        repeat (10) tick();
        pulse(S_MEASURE, S_NONE, 1'b0);
        edge_after(100, S_NONE, S_NONE, 1'b0);
        edge_after(100, S_NONE, S_NONE, 1'b0);
        edge_after(100, S_LOCKED, S_NONE, 1'b0);
        edge_after(OFFS, S_LOST, S_SEARCH, 1'b0);
        repeat (3) tick();
        check("lost2_cnt", 64'(ow_lost_cnt), 64'(2));
        check("lost2_video", 64'(ow_video_en), 64'(0));

        // Lock again, then a one-cycle reset while LOCKED.
        repeat (10) tick();
        pulse(S_MEASURE, S_NONE, 1'b0);
        edge_after(100, S_NONE, S_NONE, 1'b0);
        edge_after(100, S_NONE, S_NONE, 1'b0);
        edge_after(100, S_LOCKED, S_NONE, 1'b1);
        wait_until(last_e + 30);
        check("pre_rst_video", 64'(ow_video_en), 64'(1));
        iw_rst_n = 1'b0;
        state_q.push_back('{cyc: cyc + 1, st: 2'(S_SEARCH)});
        tick();
        iw_rst_n = 1'b1;
        check("mid_rst_state", 64'(ow_state), 64'(S_SEARCH));
        check("mid_rst_locked", 64'(ow_locked), 64'(0));
        check("mid_rst_video", 64'(ow_video_en), 64'(0));
        check("mid_rst_restart", 64'(ow_restart), 64'(0));
        check("mid_rst_frame_len", 64'(ow_frame_len), 64'(0));
        check("mid_rst_lost_cnt", 64'(ow_lost_cnt), 64'(0));

        // Periods 100,100,105,100,100,100,100: 105 and the 100 after it
        // break the run, so lock only on the last one.
        repeat (5) tick();
        pulse(S_MEASURE, S_NONE, 1'b0);
        edge_after(100, S_NONE, S_NONE, 1'b0);
        edge_after(100, S_NONE, S_NONE, 1'b0);
        edge_after(105, S_NONE, S_NONE, 1'b0);
        check("meas_frame_len_105", 64'(ow_frame_len), 64'(105));
        edge_after(100, S_NONE, S_NONE, 1'b0);
        edge_after(100, S_NONE, S_NONE, 1'b0);
        edge_after(100, S_NONE, S_NONE, 1'b0);
        edge_after(100, S_LOCKED, S_NONE, 1'b1);

        // Syncs stop after lock.
`ifdef SYNC_WATCHDOG_EN
        state_q.push_back('{cyc: last_e + 105, st: 2'(S_LOST)});
        state_q.push_back('{cyc: last_e + 106, st: 2'(S_SEARCH)});
        wait_until(last_e + 120);
        check("wd_video", 64'(ow_video_en), 64'(0));
`else
        wait_until(last_e + 400);
        check("nowd_state", 64'(ow_state), 64'(S_LOCKED));
        check("nowd_video", 64'(ow_video_en), 64'(1));
        // Late edge: period far above the maximum -> invalid -> LOST.
        pulse(S_LOST, S_SEARCH, 1'b0);
        repeat (3) tick();
`endif
        check("stop_lost_cnt", 64'(ow_lost_cnt), 64'(1));
        check("stop_frame_len", 64'(ow_frame_len), 64'(100));

        // Tolerance boundary: drift of exactly TOL still matches (102,104,106
        // lock), drift of TOL+1 in LOCKED (109 vs 106) loses lock.
        repeat (5) tick();
        pulse(S_MEASURE, S_NONE, 1'b0);
        edge_after(102, S_NONE, S_NONE, 1'b0);
        edge_after(104, S_NONE, S_NONE, 1'b0);
        edge_after(106, S_LOCKED, S_NONE, 1'b1);
        check("tol_frame_len", 64'(ow_frame_len), 64'(106));
        edge_after(109, S_LOST, S_SEARCH, 1'b0);
        repeat (3) tick();
        check("tol_lost_cnt", 64'(ow_lost_cnt), 64'(2));
        check("tol_frame_len_kept", 64'(ow_frame_len), 64'(106));

        repeat (5) tick();
        check("restart_q_empty", 64'(restart_q.size()), 64'(0));
        check("state_q_empty", 64'(state_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
